// File: rtl/nn_argmax_tracker.sv
// Running arg-max over a stream of signed elements.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sample          an element is transferred this cycle
//   first           the transferred element is element 0 (restarts the maximum)
//   last            the transferred element is the final one of the vector
//   value, index    the transferred element and its position
//   max_index       index of the largest element of the last completed vector
//   max_valid       one-cycle pulse when max_index has just been updated
module nn_argmax_tracker #(
  parameter int data_width = 16,
  parameter int IDX_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample,
  input  logic                         first,
  input  logic                         last,
  input  logic signed [data_width-1:0] value,
  input  logic        [IDX_W-1:0]      index,
  output logic        [IDX_W-1:0]      max_index,
  output logic                         max_valid
);

  logic signed [data_width-1:0] best;
  logic        [IDX_W-1:0]      best_idx;
  logic                         take;

  // Strict greater-than keeps the lower index on ties.
  assign take = first | (value > best);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best      <= '0;
      best_idx  <= '0;
      max_index <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (sample) begin
        if (take) begin
          best     <= value;
          best_idx <= index;
        end
        // The final element may itself be the new maximum, so resolve it here.
        if (last) begin
          max_index <= take ? index : best_idx;
          max_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nn_layer_serializer.sv
// Captures a parallel layer output vector and streams it one element per
// transfer (valid/ready), reporting the arg-max of each streamed vector.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_vec          parallel vector, element i at in_vec[i]
//   in_valid        in_vec holds a complete vector
//   in_ready        block is idle and will capture on in_valid
//   out             current streamed element
//   out_valid       out holds a valid element
//   out_ready       downstream accepts out
//   out_last        out holds element NUM_NEURONS-1
//   max_index       index of the largest element of the last streamed vector
//   max_valid       one-cycle pulse when max_index updates
//
// state  | meaning
// IDLE   | waiting for in_valid, in_ready high
// STREAM | presenting captured elements in ascending order
module nn_layer_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int data_width  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_NEURONS-1:0][data_width-1:0]  in_vec,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [data_width-1:0]                   out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_last,
  output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] max_index,
  output logic                                    max_valid
);

  // A one-element layer still needs a 1-bit counter/index.
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                                state, next_state;
  logic [NUM_NEURONS-1:0][data_width-1:0] vec_q;
  logic [IDX_W-1:0]                      cnt;
  logic                                  capture;
  logic                                  xfer;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign out_last  = (state == STREAM) && (cnt == LAST_IDX);
  assign out       = (state == STREAM) ? vec_q[cnt] : '0;
  assign capture   = in_ready & in_valid;
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = STREAM;
      STREAM:  if (xfer && out_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      cnt   <= '0;
    end else begin
      if (capture) begin
        vec_q <= in_vec;
        cnt   <= '0;
      end else if (xfer) begin
        cnt <= out_last ? '0 : cnt + IDX_W'(1);
      end
    end
  end

  nn_argmax_tracker #(
    .data_width (data_width),
    .IDX_W      (IDX_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .sample    (xfer),
    .first     (cnt == '0),
    .last      (out_last),
    .value     (out),
    .index     (cnt),
    .max_index (max_index),
    .max_valid (max_valid)
  );

endmodule

// File: tb/tb_nn_layer_serializer.sv
module tb_nn_layer_serializer;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0][W-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [1:0]       max_index;
  logic             max_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] cur [N];
  logic [W-1:0] nxt [N];
  logic [1:0]   prev_max;

  nn_layer_serializer #(.NUM_NEURONS(N), .data_width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .max_index (max_index),
    .max_valid (max_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arg-max: first index holding the largest signed value.
  function automatic logic [1:0] ref_argmax();
    int b = 0;
    for (int i = 1; i < N; i++)
      if ($signed(cur[i]) > $signed(cur[b])) b = i;
    return 2'(b);
  endfunction

  // Streams cur[] through the DUT. mode 0: always ready, 1: random ready,
  // 2: five stall cycles at element 1. busy: hold in_valid with nxt[] during stream.
  task automatic stream_vec(input int mode, input bit busy);
    int   k = 0;
    int   stall = 0;
    int   cyc = 0;
    bit   done = 0;
    bit   rdy;
    logic [1:0] mi;
    mi = ref_argmax();
    chk("in_ready_idle", 32'(in_ready), 1);
    for (int i = 0; i < N; i++) in_vec[i] = cur[i];
    in_valid = 1'b1;
    @(negedge clk);
    if (busy) begin
      for (int i = 0; i < N; i++) in_vec[i] = nxt[i];
    end else begin
      in_valid = 1'b0;
    end
    while (!done && cyc < 100) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("in_ready_busy", 32'(in_ready), 0);
      chk("out_data", 32'(out), 32'(cur[k]));
      chk("out_last", 32'(out_last), 32'(k == N - 1));
      chk("max_valid_quiet", 32'(max_valid), 0);
      chk("max_index_hold", 32'(max_index), 32'(prev_max));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(k == 1 && stall < 5);
          if (!rdy) stall++;
        end
      endcase
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        if (k == N - 1) done = 1;
        else k++;
      end
    end
    chk("stream_done", 32'(done), 1);
    out_ready = 1'b0;
    chk("out_valid_end", 32'(out_valid), 0);
    chk("in_ready_end", 32'(in_ready), 1);
    chk("max_valid_pulse", 32'(max_valid), 1);
    chk("max_index", 32'(max_index), 32'(mi));
    prev_max = mi;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_vec = '0;
    prev_max = 2'd0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_max_valid", 32'(max_valid), 0);
    chk("rst_max_index", 32'(max_index), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Mixed-sign vector, full throughput
    cur[0] = 16'h0010; cur[1] = 16'hFFF0; cur[2] = 16'h0030; cur[3] = 16'h0005;
    stream_vec(0, 1'b0);
    // Same vector with a 5-cycle stall at element 1
    stream_vec(2, 1'b0);
    // Signed extremes and a tie
    cur[0] = 16'h8000; cur[1] = 16'h7FFF; cur[2] = 16'h7FFF; cur[3] = 16'h0000;
    stream_vec(0, 1'b0);

    // New data offered while busy; captured only after return to IDLE
    for (int i = 0; i < N; i++) begin
      cur[i] = 16'($urandom);
      nxt[i] = 16'($urandom);
    end
    stream_vec(1, 1'b1);
    for (int i = 0; i < N; i++) cur[i] = nxt[i];
    stream_vec(1, 1'b0);

    // Random vectors with random backpressure (small range forces ties)
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        cur[i] = (t < 4) ? 16'($urandom) : 16'($signed(3'($urandom)));
      stream_vec(1, 1'b0);
    end

    // Reset after three transfers
    for (int i = 0; i < N; i++) cur[i] = 16'($urandom);
    for (int i = 0; i < N; i++) in_vec[i] = cur[i];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_out", 32'(out), 32'(cur[3]));
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_last", 32'(out_last), 0);
    @(negedge clk);
    chk("mid_rst_max_valid", 32'(max_valid), 0);
    chk("mid_rst_max_index", 32'(max_index), 0);
    rst = 1'b0;
    prev_max = 2'd0;
    @(negedge clk);
    chk("post_rst_max_valid", 32'(max_valid), 0);

    // Recovery after reset
    for (int i = 0; i < N; i++) cur[i] = 16'($urandom);
    stream_vec(1, 1'b0);
    @(negedge clk);
    chk("max_valid_one_cycle", 32'(max_valid), 0);
    chk("max_index_held", 32'(max_index), 32'(prev_max));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
